aes_key_schedule: RTL
=====================

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 SHALL have parameter MAX_KEY_BITS, default 256, meaning the largest key length supported (128, 192 or 256); it sets round-key storage to 4*(MAX_NR+1) words, where MAX_NR = 10/12/14.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk_sys and rst.
REQ-003 clk_sys  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle request to expand cipher_key.
REQ-006 key_len  input  2  key length: 00=128, 01=192, 10=256, 11=illegal.
REQ-007 cipher_key  input  256  key, MSB-aligned; w0=[255:224]; unused LSBs ignored.
REQ-008 busy  output  1  expansion in progress.
REQ-009 done  output  1  one-cycle pulse after the last word is written.
REQ-010 keys_valid  output  1  stored schedule is complete and readable.
REQ-011 err  output  1  one-cycle pulse when start is rejected.
REQ-012 nr  output  4  round count of the stored schedule: 10, 12 or 14.
REQ-013 rk_rd_en, rk_rd_idx  input  1, 4  round-key read request and index.
REQ-014 rk_rd_data, rk_rd_valid, rk_rd_err  output  128, 1, 1  read response, registered.

Function
REQ-015 SHALL implement FSM states IDLE, EXPAND and DONE; the DONE state lasts one cycle, then returns to IDLE.
REQ-016 start SHALL be accepted only in IDLE, or in IDLE with keys_valid=1; start while busy SHALL be ignored, with no err pulse.
REQ-017 start with key_len=11, or with a key length above MAX_KEY_BITS, SHALL be rejected: err pulses the next cycle, state is unchanged, keys_valid is unchanged.
REQ-018 On the accept edge, the block SHALL latch Nk (4/6/8), write w0..w(Nk-1) from cipher_key, clear keys_valid, set busy, and set rcon=0x01.
REQ-019 In EXPAND, exactly one word w[i] SHALL be written per cycle, for i=Nk..4*(Nr+1)-1, using a single 4-byte S-box instance.
REQ-020 Each word SHALL be computed as w[i]=w[i-Nk]^temp, with temp=w[i-1], modified as follows:
- if i mod Nk==0: temp=SubWord(RotWord(w[i-1]))^{rcon,24'h0}, then rcon<=xtime(rcon) (0x80 wraps to 0x1B);
- if Nk==8 and i mod Nk==4: temp=SubWord(w[i-1]).
REQ-021 RotWord SHALL be a left byte rotation ({b1,b2,b3,b0}); the index counter SHALL be 6 bits and SHALL be tracked modulo Nk without a divider.
REQ-022 Latency from the accept edge to done SHALL be 4*(Nr+1)-Nk+1 cycles: 41 (128), 47 (192) or 53 (256).
REQ-023 With done, the block SHALL set keys_valid=1 and busy=0 and update nr; keys_valid SHALL hold until the next accepted start or reset.
REQ-024 A read SHALL respond one cycle after rk_rd_en, as follows:
- if keys_valid=1 and rk_rd_idx<=nr: rk_rd_valid=1 and rk_rd_data={w[4k],w[4k+1],w[4k+2],w[4k+3]} with k=rk_rd_idx;
- otherwise: rk_rd_err=1, rk_rd_valid=0 and rk_rd_data=0.
REQ-025 rk_rd_valid and rk_rd_err SHALL be single-cycle pulses; rk_rd_data SHALL hold its last value when no read is made.
REQ-026 A read issued in the same cycle as done SHALL return rk_rd_err=1; a read issued on the cycle after done SHALL succeed.
REQ-027 rk_rd_idx 0 SHALL equal the first four key words, i.e. cipher_key[255:128] for AES-128.

Reset
REQ-028 When rst is asserted, the block SHALL immediately force: state=IDLE, busy=0, done=0, err=0, keys_valid=0, nr=0, rk_rd_valid=0, rk_rd_err=0, rk_rd_data=0.
REQ-029 Word storage need not be reset; rst mid-EXPAND SHALL abandon the schedule and no done SHALL follow.
REQ-030 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-031 AES-128 case: key 2b7e151628aed2a6abf7158809cf4f3c -> done 41 cycles after accept, nr=10; rk 1 = a0fafe1788542cb123a339392a6c7605; rk 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 AES-192 case: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 47 cycles, nr=12; rk 12 = e98ba06f448c773c8ecc720401002202.
REQ-033 AES-256 case: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 53 cycles, nr=14; rk 14 = fe4890d1e6188d0b046df344706c631e.
REQ-034 Reject case: start with key_len=11 -> err pulse and keys_valid unchanged; start at cycle 10 of an expansion -> ignored and original done timing kept; read of idx 11 after an AES-128 expansion -> rk_rd_err=1.
REQ-035 Reset case: rst at cycle 20 of an AES-256 expansion -> busy=0 and keys_valid=0 at once and no done pulse; a following AES-128 run still meets REQ-031.

Source files
------------

// File: rtl/aes_key_schedule.sv
// AES key expansion engine: expands a 128/192/256-bit cipher key into the full
// round-key schedule, one 32-bit word per cycle, and serves 128-bit round keys.
module aes_key_schedule #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] cipher_key,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic         err,
    output logic [3:0]   nr,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data,
    output logic         rk_rd_valid,
    output logic         rk_rd_err
);
    localparam int MAX_NR    = (MAX_KEY_BITS >= 256) ? 14 : (MAX_KEY_BITS >= 192) ? 12 : 10;
    localparam int MAX_WORDS = 4 * (MAX_NR + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)), gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [1:0]   state_reg;
    logic [3:0]   nk_reg;
    logic [2:0]   mod_reg;
    logic [5:0]   idx_reg;
    logic [5:0]   last_reg;
    logic [3:0]   nr_pend_reg;
    logic [7:0]   rcon_reg;
    logic [255:0] win_reg;
    logic         busy_reg, done_reg, err_reg, keys_valid_reg;
    logic [3:0]   nr_reg;
    logic [127:0] rd_data_reg;
    logic         rd_valid_reg, rd_err_reg;

    logic [31:0]  w_mem [0:MAX_WORDS-1];

    logic         len_ok, accept, reject, rd_ok;
    logic [3:0]   nk_in, nr_in;
    logic [5:0]   last_in;
    logic [255:0] win_load;
    logic [31:0]  prev_word, back_word, sub_in, sub_out, temp_word, new_word;
    logic [2:0]   mod_next;
    logic [5:0]   rd_base;

    assign len_ok  = (key_len != 2'b11) && ((128 + 64 * int'(key_len)) <= MAX_KEY_BITS);
    assign accept  = start && (state_reg == S_IDLE) && len_ok;
    assign reject  = start && (state_reg == S_IDLE) && !len_ok;
    assign nk_in   = 4'd4 + {1'b0, key_len, 1'b0};
    assign nr_in   = 4'd10 + {1'b0, key_len, 1'b0};
    assign last_in = 6'd43 + {1'b0, key_len, 3'b000};

    // The window holds w[i-8..i-1]; the key is loaded right-aligned so w[Nk-1] is newest.
    always_comb begin
        case (key_len)
            2'b00:   win_load = cipher_key >> 128;
            2'b01:   win_load = cipher_key >> 64;
            default: win_load = cipher_key;
        endcase
    end

    assign prev_word = win_reg[31:0];
    always_comb begin
        case (nk_reg)
            4'd4:    back_word = win_reg[127:96];
            4'd6:    back_word = win_reg[191:160];
            default: back_word = win_reg[255:224];
        endcase
    end

    assign sub_in = (mod_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_out[8*gi +: 8] = sbox(sub_in[8*gi +: 8]);
        end
    endgenerate

    always_comb begin
        if (mod_reg == 3'd0)
            temp_word = sub_out ^ {rcon_reg, 24'h000000};
        else if (nk_reg == 4'd8 && mod_reg == 3'd4)
            temp_word = sub_out;
        else
            temp_word = prev_word;
    end

    assign new_word = back_word ^ temp_word;
    assign mod_next = (({1'b0, mod_reg} + 4'd1) == nk_reg) ? 3'd0 : mod_reg + 3'd1;

    // Reads are refused during the done cycle so the first valid read follows it.
    assign rd_ok   = keys_valid_reg && !done_reg && (rk_rd_idx <= nr_reg);
    assign rd_base = {rk_rd_idx, 2'b00};

    always_ff @(posedge clk_sys) begin
        if (accept) begin
            for (int k = 0; k < 8; k++)
                if (k < int'(nk_in)) w_mem[k] <= cipher_key[255 - 32*k -: 32];
        end else if (state_reg == S_EXPAND) begin
            w_mem[idx_reg] <= new_word;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            nk_reg         <= 4'd4;
            mod_reg        <= 3'd0;
            idx_reg        <= 6'd0;
            last_reg       <= 6'd0;
            nr_pend_reg    <= 4'd0;
            rcon_reg       <= 8'h01;
            win_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            keys_valid_reg <= 1'b0;
            nr_reg         <= 4'd0;
            rd_data_reg    <= '0;
            rd_valid_reg   <= 1'b0;
            rd_err_reg     <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_err_reg   <= 1'b0;
            if (rk_rd_en) begin
                if (rd_ok) begin
                    rd_valid_reg <= 1'b1;
                    rd_data_reg  <= {w_mem[rd_base], w_mem[rd_base + 6'd1],
                                     w_mem[rd_base + 6'd2], w_mem[rd_base + 6'd3]};
                end else begin
                    rd_err_reg  <= 1'b1;
                    rd_data_reg <= '0;
                end
            end
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        nk_reg         <= nk_in;
                        nr_pend_reg    <= nr_in;
                        last_reg       <= last_in;
                        idx_reg        <= {2'b00, nk_in};
                        mod_reg        <= 3'd0;
                        rcon_reg       <= 8'h01;
                        win_reg        <= win_load;
                        keys_valid_reg <= 1'b0;
                        busy_reg       <= 1'b1;
                        state_reg      <= S_EXPAND;
                    end else if (reject) begin
                        err_reg <= 1'b1;
                    end
                end
                S_EXPAND: begin
                    win_reg <= {win_reg[223:0], new_word};
                    idx_reg <= idx_reg + 6'd1;
                    mod_reg <= mod_next;
                    if (mod_reg == 3'd0)
                        rcon_reg <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
                    if (idx_reg == last_reg) state_reg <= S_DONE;
                end
                S_DONE: begin
                    done_reg       <= 1'b1;
                    keys_valid_reg <= 1'b1;
                    busy_reg       <= 1'b0;
                    nr_reg         <= nr_pend_reg;
                    state_reg      <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;
    assign keys_valid  = keys_valid_reg;
    assign nr          = nr_reg;
    assign rk_rd_data  = rd_data_reg;
    assign rk_rd_valid = rd_valid_reg;
    assign rk_rd_err   = rd_err_reg;
endmodule
